eth_rx: RTL
===========

Name: eth_rx

Overview:
- RMII receive datapath; the receive-side counterpart of eth_tx.
- Samples the 2-bit PHY receive bus on the 50 MHz RMII clock and strips the preamble/SFD.
- Assembles LSB-first bytes, emits them as a byte stream with start/end markers, and checks frame length and CRC-32 FCS.
- Sits between the PHY pins and the upstream packet parser/FIFO.

Parameters:
pMIN_FRAME, 64, minimum legal frame length in bytes after SFD, FCS included
pMAX_FRAME, 1518, maximum legal frame length in bytes after SFD, FCS included

Ports:
Clk  input  1  RMII reference clock, 50 MHz; single clock domain
Rst  input  1  synchronous reset, active-high
Rx_Data  input  2  RMII RXD; bit[0] is the earlier bit on the wire
Crs_Dv  input  1  RMII CRS_DV; frame data valid
Rx_Byte  output  8  received byte (destination address through FCS)
Rx_Byte_Valid  output  1  one-cycle strobe, Rx_Byte valid
Rx_Sof  output  1  high with the first Rx_Byte_Valid of a frame
Rx_Eof  output  1  one-cycle end-of-frame strobe; Rx_Err_Code valid on it
Rx_Err_Code  output  2  0 OK, 1 CRC, 2 length, 3 alignment
Rx_Good_Cnt  output  16  good-frame count (optional feature)
Rx_Bad_Cnt  output  16  bad-frame count (optional feature)

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0. FSM goes to IDLE. Byte/dibit counters are cleared. CRC register is set to 32'hFFFFFFFF.
  - Crs_Dv_d1 is set to 1, so a frame already in progress at reset release is ignored.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - Crs_Dv rising edge (Crs_Dv=1, Crs_Dv_d1=0) -> PREAMBLE.
- PREAMBLE:
  - Rx_Data=2'b00 or 2'b01: stay.
  - Rx_Data=2'b11 (final SFD dibit): -> DATA; clear dibit counter, byte counter and CRC.
  - Rx_Data=2'b10 (false carrier): -> DROP.
  - Crs_Dv=0: -> IDLE. No Rx_Eof is issued.
- DATA:
  - Each cycle with Crs_Dv=1, shift Rx_Data into the byte register from the MSB end: byte <= {Rx_Data, byte[7:2]}. The dibit counter wraps 3->0.
  - The 4th dibit is sampled in cycle N. In cycle N+1, Rx_Byte is presented with Rx_Byte_Valid=1, the byte is fed to the CRC, and the byte counter increments.
  - Rx_Sof accompanies byte 0 only.
  - If the byte counter would exceed pMAX_FRAME: suppress further bytes and go to DROP with length error latched.
- End of frame in DATA:
  - Crs_Dv=0 sampled in cycle M -> Rx_Eof=1 in cycle M+1, with the error code, then IDLE.
  - Error priority: alignment (dibit counter != 0) > length (count < pMIN_FRAME) > CRC (register after the last byte != residue 32'hDEBB20E3).
  - The last byte's strobe (cycle M) and Rx_Eof (cycle M+1) never coincide.
- DROP:
  - No byte output. Wait for Crs_Dv=0.
  - Rx_Eof pulses with code 2 only if DROP was entered from DATA. A false carrier produces no Rx_Eof.
- CRC:
  - Reflected CRC-32: polynomial 32'hEDB88320, initial value 32'hFFFFFFFF, one byte per update.
  - Computed over all bytes including the FCS, then compared to the residue. No final inversion in the compare.
- Rx_Byte holds its last value between strobes.
- Rx_Byte_Valid and Rx_Eof are single-cycle pulses.
- FCS bytes are passed through; stripping them is the consumer's job.
- Rst mid-frame aborts with no Rx_Eof. The remainder of that frame is ignored via the Crs_Dv_d1 rule.

Optional Feature:
ETH_RX_STATS_EN
- Defined:
  - Rx_Good_Cnt increments on Rx_Eof with code 0.
  - Rx_Bad_Cnt increments on Rx_Eof with a nonzero code.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on Rst.
- Undefined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- eth_rx_pkg.vh holds:
  - state encodings `RX_IDLE/`RX_PREAMBLE/`RX_DATA/`RX_DROP
  - `pMII_WIDTH (2)
  - error codes `RX_ERR_NONE/CRC/LEN/ALIGN
  - `pCRC_POLY 32'hEDB88320, `pCRC_INIT 32'hFFFFFFFF, `pCRC_RESIDUE 32'hDEBB20E3
- One sub-module, eth_rx_crc_chk:
  - Byte-wide reflected CRC register with Init/Byte_Valid/Byte inputs and a Crc_Match output.
  - Combinational next-state; registered output.

Test Plan:
- 7x 0x55 + 0xD5, then a 64-byte frame (dest FF:FF:FF:FF:FF:FF, src 00..00, type 0x0800, 46 x 0x00, valid FCS) -> 64 strobes; Rx_Sof with Rx_Byte=0xFF; Rx_Eof with code 0.
- Same frame with one payload bit flipped -> 64 strobes; Rx_Eof with code 1.
- 60-byte frame with valid FCS -> 60 strobes; code 2. A 1600-byte frame -> exactly 1518 strobes; code 2.
- Crs_Dv drops after 3 dibits of byte 70 -> 69 strobes; code 3.
- Crs_Dv high with dibits 00,00,01,01,10 -> no strobe, no Rx_Eof. A following valid frame is received with code 0.
- Rst pulsed at byte 20 with Crs_Dv still high -> outputs 0 and no Rx_Eof. The rest of that frame is ignored; the next frame is received with code 0. With ETH_RX_STATS_EN, Rx_Good_Cnt=1.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII receive path: FSM states, error codes
// and the byte-wide reflected CRC-32 update.
package eth_rx_pkg;

    localparam int unsigned MII_W       = 2;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_PREAMBLE = 2'd1,
        RX_DATA     = 2'd2,
        RX_DROP     = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        RX_ERR_NONE  = 2'd0,
        RX_ERR_CRC   = 2'd1,
        RX_ERR_LEN   = 2'd2,
        RX_ERR_ALIGN = 2'd3
    } rx_err_e;

    // One byte through the reflected CRC-32, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_crc_chk.sv
// Byte-wide reflected CRC-32 accumulator; crc_match flags the good-frame residue
// one cycle after the byte that produced it.
module eth_rx_crc_chk
    import eth_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       byte_valid,
    input  logic [7:0] data,
    output logic       crc_match
);

    logic [31:0] crc;
    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc;
        if (init) begin
            crc_next = CRC_INIT;
        end else if (byte_valid) begin
            crc_next = crc32_byte(crc, data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc       <= CRC_INIT;
            crc_match <= 1'b0;
        end else begin
            crc       <= crc_next;
            crc_match <= (crc_next == CRC_RESIDUE);
        end
    end

endmodule

// File: rtl/eth_rx.sv
// RMII receiver: strips preamble/SFD, emits LSB-first bytes with SOF/EOF and
// checks length and FCS. Define ETH_RX_STATS_EN to build good/bad frame counters.
module eth_rx
    import eth_rx_pkg::*;
#(
    parameter int unsigned pMIN_FRAME = 64,
    parameter int unsigned pMAX_FRAME = 1518
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [MII_W-1:0] Rx_Data,
    input  logic             Crs_Dv,
    output logic [7:0]       Rx_Byte,
    output logic             Rx_Byte_Valid,
    output logic             Rx_Sof,
    output logic             Rx_Eof,
    output logic [1:0]       Rx_Err_Code,
    output logic [15:0]      Rx_Good_Cnt,
    output logic [15:0]      Rx_Bad_Cnt
);

    localparam int unsigned CNT_W = $clog2(pMAX_FRAME + 1);

    rx_state_e        state;
    logic             crs_d1;
    logic [1:0]       dibit_cnt;
    logic [7:0]       shreg;
    logic [CNT_W-1:0] byte_cnt;
    logic             drop_len;

    logic       byte_done;
    logic       at_max;
    logic [7:0] byte_next;
    logic       crc_init;
    logic       crc_valid;
    logic       crc_match;
    rx_err_e    eof_code;

    // The byte being completed this cycle goes to the CRC immediately so the
    // match flag is settled by the time carrier loss is seen.
    always_comb begin
        byte_next = {Rx_Data, shreg[7:2]};
        byte_done = (state == RX_DATA) && Crs_Dv && (dibit_cnt == 2'd3);
        at_max    = (byte_cnt == CNT_W'(pMAX_FRAME));
        crc_init  = (state == RX_PREAMBLE) && Crs_Dv && (Rx_Data == 2'b11);
        crc_valid = byte_done && !at_max;
        if (dibit_cnt != 2'd0) begin
            eof_code = RX_ERR_ALIGN;
        end else if (byte_cnt < CNT_W'(pMIN_FRAME)) begin
            eof_code = RX_ERR_LEN;
        end else if (!crc_match) begin
            eof_code = RX_ERR_CRC;
        end else begin
            eof_code = RX_ERR_NONE;
        end
    end

    eth_rx_crc_chk u_crc (
        .clk        (Clk),
        .rst        (Rst),
        .init       (crc_init),
        .byte_valid (crc_valid),
        .data       (byte_next),
        .crc_match  (crc_match)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= RX_IDLE;
            crs_d1        <= 1'b1;
            dibit_cnt     <= 2'd0;
            shreg         <= 8'd0;
            byte_cnt      <= '0;
            drop_len      <= 1'b0;
            Rx_Byte       <= 8'd0;
            Rx_Byte_Valid <= 1'b0;
            Rx_Sof        <= 1'b0;
            Rx_Eof        <= 1'b0;
            Rx_Err_Code   <= 2'd0;
        end else begin
            crs_d1        <= Crs_Dv;
            Rx_Byte_Valid <= 1'b0;
            Rx_Sof        <= 1'b0;
            Rx_Eof        <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (Crs_Dv && !crs_d1) begin
                        state <= RX_PREAMBLE;
                    end
                end
                RX_PREAMBLE: begin
                    if (!Crs_Dv) begin
                        state <= RX_IDLE;
                    end else if (Rx_Data == 2'b11) begin
                        state     <= RX_DATA;
                        dibit_cnt <= 2'd0;
                        byte_cnt  <= '0;
                    end else if (Rx_Data == 2'b10) begin
                        state    <= RX_DROP;
                        drop_len <= 1'b0;
                    end
                end
                RX_DATA: begin
                    if (!Crs_Dv) begin
                        Rx_Eof      <= 1'b1;
                        Rx_Err_Code <= eof_code;
                        state       <= RX_IDLE;
                    end else if (byte_done && at_max) begin
                        state    <= RX_DROP;
                        drop_len <= 1'b1;
                    end else begin
                        shreg     <= byte_next;
                        dibit_cnt <= 2'(dibit_cnt + 2'd1);
                        if (byte_done) begin
                            Rx_Byte       <= byte_next;
                            Rx_Byte_Valid <= 1'b1;
                            Rx_Sof        <= (byte_cnt == '0);
                            byte_cnt      <= CNT_W'(byte_cnt + 1'b1);
                        end
                    end
                end
                RX_DROP: begin
                    if (!Crs_Dv) begin
                        if (drop_len) begin
                            Rx_Eof      <= 1'b1;
                            Rx_Err_Code <= RX_ERR_LEN;
                        end
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

`ifdef ETH_RX_STATS_EN
    // Saturating frame statistics, updated from the registered end-of-frame strobe.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rx_Good_Cnt <= 16'd0;
            Rx_Bad_Cnt  <= 16'd0;
        end else if (Rx_Eof) begin
            if (Rx_Err_Code == RX_ERR_NONE) begin
                if (Rx_Good_Cnt != 16'hFFFF) Rx_Good_Cnt <= 16'(Rx_Good_Cnt + 16'd1);
            end else begin
                if (Rx_Bad_Cnt != 16'hFFFF) Rx_Bad_Cnt <= 16'(Rx_Bad_Cnt + 16'd1);
            end
        end
    end
`else
    assign Rx_Good_Cnt = 16'd0;
    assign Rx_Bad_Cnt  = 16'd0;
`endif

endmodule
